counter_nbit_mod: RTL and testbench
===================================

COUNTER_NBIT_MOD -- requirements
Module: counter_nbit_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MODULUS, default 256: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step, legal range 1..65536.
REQ-004 Parameter SATURATE, default 0: 0 selects wrap-around, 1 selects hold at the boundary.
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 CLR  in  1  synchronous clear of the count and the prescaler.
REQ-008 LOAD  in  1  synchronous parallel load of D.
REQ-009 D  in  WIDTH  load value.
REQ-010 EN  in  1  count enable; gates the prescaler and the count step.
REQ-011 UP  in  1  direction: 1 counts up, 0 counts down.
REQ-012 Q  out  WIDTH  current count, registered.
REQ-013 TC  out  1  terminal count, combinational from Q and UP.
REQ-014 WRAP  out  1  registered one-cycle boundary pulse.

Function
REQ-015 Priority per edge SHALL be CLR > LOAD > count step.
REQ-016 CLR SHALL set Q=0 and prescaler=0, and WRAP SHALL be 0 in the following cycle.
REQ-017 LOAD SHALL set Q=D when D<MODULUS, else Q=MODULUS-1 (clamp); LOAD SHALL reset the prescaler to 0; WRAP SHALL be 0 next cycle.
REQ-018 The prescaler SHALL advance only when EN=1, hold when EN=0, and issue an internal tick when it equals PRESCALE-1 with EN=1, then return to 0.
REQ-019 With PRESCALE=1 the tick SHALL equal EN, giving one step per enabled cycle with no extra latency.
REQ-020 A count step SHALL occur only on a tick with CLR=0 and LOAD=0; Q SHALL update at that same edge.
REQ-021 Up step: Q<MODULUS-1 -> Q+1; Q=MODULUS-1 -> 0 (SATURATE=0) or hold (SATURATE=1).
REQ-022 Down step: Q>0 -> Q-1; Q=0 -> MODULUS-1 (SATURATE=0) or hold (SATURATE=1).
REQ-023 WRAP SHALL be 1 for exactly the cycle after any step taken at a boundary (REQ-021/022 boundary case), in both modes; otherwise 0.
REQ-024 TC SHALL be 1 when (UP=1 and Q=MODULUS-1) or (UP=0 and Q=0).
REQ-025 A change of UP SHALL take effect on the next step; the prescaler phase SHALL NOT reset on a change of UP.
REQ-026 Arithmetic SHALL be performed in WIDTH bits; when MODULUS=2**WIDTH, wrap SHALL equal natural binary overflow.

Reset
REQ-027 RST_N=0 SHALL immediately force Q=0, WRAP=0 and prescaler=0, regardless of CLK.
REQ-028 Reset asserted mid-operation SHALL discard any pending prescaler phase; counting SHALL resume from 0 on the first tick after RST_N rises.
REQ-029 No output SHALL be X after reset; TC SHALL equal (UP=0) while Q=0.

Structure
REQ-030 Default parameter values and the prescaler width constant (clog2 of PRESCALE, minimum 1) SHALL live in the shared package counter_pkg.
REQ-031 The prescaler SHALL be a separate sub-module, counter_prescaler (ports CLK, RST_N, CLR, EN, TICK), instantiated once.
REQ-032 Parameter legality (REQ-001..004) SHALL be checked at elaboration, and an illegal value SHALL be a fatal error.

Verification
REQ-033 WIDTH=4, MODULUS=10, UP=1, EN=1 from reset -> Q steps 0..9, then 0; WRAP=1 in the cycle after the 9->0 step; TC=1 while Q=9.
REQ-034 Same configuration, UP=0 from Q=0 -> Q=9 next edge, WRAP pulse; with SATURATE=1 -> Q holds 0, WRAP still pulses.
REQ-035 PRESCALE=3, EN toggled 1,1,0,1 -> Q increments once, on the third enabled cycle; the EN=0 cycle holds the prescaler.
REQ-036 LOAD=1, D=12, MODULUS=10 -> Q=9; LOAD and CLR together -> Q=0; LOAD with a concurrent tick -> load wins.
REQ-037 RST_N low mid-count at Q=5, PRESCALE=4 with the phase at 2 -> Q=0 immediately; after release, first step after 4 enabled cycles.
REQ-038 WIDTH=8, MODULUS=256, Q=255 up step -> Q=0 with WRAP; random EN/UP/LOAD for 10k cycles matched against a reference model.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults and helpers for the modulo counter and its prescaler.
package counter_pkg;

  localparam int     DEF_WIDTH    = 8;
  localparam longint DEF_MODULUS  = 256;
  localparam int     DEF_PRESCALE = 1;
  localparam int     DEF_SATURATE = 0;

  // What the counter register does on a given edge, in priority order.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_CLR
  } op_e;

  // Bits needed to hold a prescaler phase 0..prescale-1, never fewer than 1.
  function automatic int presc_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; TICK marks the last enabled cycle of each period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  input  logic EN,
  output logic TICK
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // With PRESCALE=1 LAST is 0, phase never leaves 0 and TICK collapses to EN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase <= '0;
    end else if (CLR) begin
      phase <= '0;
    end else if (EN) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

  assign TICK = EN && (phase == LAST);

endmodule

// File: rtl/counter_nbit_mod.sv
// Up/down modulo-MODULUS counter with prescaled enable, clear, clamped load and wrap pulse.
module counter_nbit_mod
  import counter_pkg::*;
#(
  parameter int     WIDTH    = DEF_WIDTH,
  parameter longint MODULUS  = DEF_MODULUS,
  parameter int     PRESCALE = DEF_PRESCALE,
  parameter int     SATURATE = DEF_SATURATE
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "counter_nbit_mod: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $fatal(1, "counter_nbit_mod: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $fatal(1, "counter_nbit_mod: PRESCALE=%0d outside 1..65536", PRESCALE);
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
    $fatal(1, "counter_nbit_mod: SATURATE=%0d must be 0 or 1", SATURATE);
  end

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

  logic             tick;
  logic             at_bound;
  op_e              op;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // LOAD restarts the prescaler as well, so it shares the clear path.
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CLR  (CLR | LOAD),
    .EN   (EN),
    .TICK (tick)
  );

  assign at_bound = UP ? (Q == QMAX) : (Q == '0);
  assign TC       = at_bound;

  always_comb begin
    op = OP_HOLD;
    if (CLR) begin
      op = OP_CLR;
    end else if (LOAD) begin
      op = OP_LOAD;
    end else if (tick) begin
      op = OP_STEP;
    end
  end

  // When MODULUS=2**WIDTH, QMAX is all ones and the wrap matches binary overflow.
  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    case (op)
      OP_CLR:  q_next = '0;
      OP_LOAD: q_next = (D > QMAX) ? QMAX : D;
      OP_STEP: begin
        wrap_next = at_bound;
        if (at_bound) begin
          if (SATURATE != 0) begin
            q_next = Q;
          end else begin
            q_next = UP ? '0 : QMAX;
          end
        end else begin
          q_next = UP ? Q + 1'b1 : Q - 1'b1;
        end
      end
      default: q_next = Q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else begin
      Q    <= q_next;
      WRAP <= wrap_next;
    end
  end

endmodule

// File: tb/tb_counter_nbit_mod.sv
// Directed and randomized checks of counter_nbit_mod across several parameter sets.
module tb_counter_nbit_mod;

  logic       CLK;
  logic       RST_N;
  logic       CLR;
  logic       LOAD;
  logic       EN;
  logic       UP;
  logic [7:0] D;

  logic [3:0] q_a, q_s, q_p3, q_p4;
  logic       tc_a, tc_s, tc_p3, tc_p4;
  logic       w_a, w_s, w_p3, w_p4;
  logic [7:0] q_b;
  logic       tc_b, w_b;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  counter_nbit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .D(D[3:0]), .EN(EN), .UP(UP),
    .Q(q_a), .TC(tc_a), .WRAP(w_a));
  counter_nbit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_s (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .D(D[3:0]), .EN(EN), .UP(UP),
    .Q(q_s), .TC(tc_s), .WRAP(w_s));
  counter_nbit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_p3 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .D(D[3:0]), .EN(EN), .UP(UP),
    .Q(q_p3), .TC(tc_p3), .WRAP(w_p3));
  counter_nbit_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .SATURATE(0)) u_p4 (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .D(D[3:0]), .EN(EN), .UP(UP),
    .Q(q_p4), .TC(tc_p4), .WRAP(w_p4));
  counter_nbit_mod u_b (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .D(D), .EN(EN), .UP(UP),
    .Q(q_b), .TC(tc_b), .WRAP(w_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Independent reference step for one counter configuration.
  task automatic mstep(input int md, input bit sat, input bit tk, input bit up,
                       input bit clr, input bit ld, input int d, input int q,
                       output int qn, output bit w);
    w  = 1'b0;
    qn = q;
    if (clr) qn = 0;
    else if (ld) qn = (d >= md) ? md - 1 : d;
    else if (tk) begin
      if (up) begin
        if (q == md - 1) begin w = 1'b1; qn = sat ? q : 0; end
        else qn = q + 1;
      end else begin
        if (q == 0) begin w = 1'b1; qn = sat ? q : md - 1; end
        else qn = q - 1;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++; if (q_a !== 4'd0) $display("FAIL reset_q_a: got %0d want 0", q_a); else pass_cnt++;
    chk_cnt++; if (w_a !== 1'b0) $display("FAIL reset_wrap_a: got %b want 0", w_a); else pass_cnt++;
    chk_cnt++; if (tc_a !== 1'b1) $display("FAIL reset_tc_down: got %b want 1", tc_a); else pass_cnt++;
    chk_cnt++; if (q_b !== 8'd0) $display("FAIL reset_q_b: got %0d want 0", q_b); else pass_cnt++;
    chk_cnt++; if (w_b !== 1'b0) $display("FAIL reset_wrap_b: got %b want 0", w_b); else pass_cnt++;
    UP = 1'b1;
    #1;
    chk_cnt++; if (tc_a !== 1'b0) $display("FAIL reset_tc_up: got %b want 0", tc_a); else pass_cnt++;
    EN = 1'b1;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd0) $display("FAIL reset_hold_q: got %0d want 0", q_a); else pass_cnt++;
    RST_N = 1'b1;
    EN    = 1'b0;
  endtask

  task automatic test_up_wrap();
    EN = 1'b0; UP = 1'b1; CLR = 1'b1;
    cyc(1);
    CLR = 1'b0; EN = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      chk_cnt++; if (q_a !== 4'(i)) $display("FAIL up_q[%0d]: got %0d want %0d", i, q_a, i); else pass_cnt++;
      chk_cnt++; if (w_a !== 1'b0) $display("FAIL up_wrap[%0d]: got %b want 0", i, w_a); else pass_cnt++;
      chk_cnt++; if (tc_a !== (i == 9)) $display("FAIL up_tc[%0d]: got %b want %b", i, tc_a, i == 9); else pass_cnt++;
    end
    cyc(1);
    chk_cnt++; if (q_a !== 4'd0) $display("FAIL wrap_q: got %0d want 0", q_a); else pass_cnt++;
    chk_cnt++; if (w_a !== 1'b1) $display("FAIL wrap_pulse: got %b want 1", w_a); else pass_cnt++;
    chk_cnt++; if (q_s !== 4'd9) $display("FAIL sat_up_hold: got %0d want 9", q_s); else pass_cnt++;
    chk_cnt++; if (w_s !== 1'b1) $display("FAIL sat_up_wrap: got %b want 1", w_s); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd1) $display("FAIL wrap_next_q: got %0d want 1", q_a); else pass_cnt++;
    chk_cnt++; if (w_a !== 1'b0) $display("FAIL wrap_one_cycle: got %b want 0", w_a); else pass_cnt++;
  endtask

  task automatic test_down();
    EN = 1'b0; CLR = 1'b1;
    cyc(1);
    CLR = 1'b0; UP = 1'b0;
    #1;
    chk_cnt++; if (tc_a !== 1'b1) $display("FAIL down_tc: got %b want 1", tc_a); else pass_cnt++;
    EN = 1'b1;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd9) $display("FAIL down_wrap_q: got %0d want 9", q_a); else pass_cnt++;
    chk_cnt++; if (w_a !== 1'b1) $display("FAIL down_wrap: got %b want 1", w_a); else pass_cnt++;
    chk_cnt++; if (q_s !== 4'd0) $display("FAIL sat_down_hold: got %0d want 0", q_s); else pass_cnt++;
    chk_cnt++; if (w_s !== 1'b1) $display("FAIL sat_down_wrap: got %b want 1", w_s); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd8) $display("FAIL down_q: got %0d want 8", q_a); else pass_cnt++;
    chk_cnt++; if (w_a !== 1'b0) $display("FAIL down_wrap_clear: got %b want 0", w_a); else pass_cnt++;
    chk_cnt++; if (w_s !== 1'b1) $display("FAIL sat_down_wrap2: got %b want 1", w_s); else pass_cnt++;
  endtask

  task automatic test_prescale();
    bit en_seq[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int exp_q[4]  = '{0, 0, 0, 1};
    EN = 1'b0; UP = 1'b1; CLR = 1'b1;
    cyc(1);
    CLR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      EN = en_seq[i];
      cyc(1);
      chk_cnt++; if (q_p3 !== 4'(exp_q[i])) $display("FAIL presc3_q[%0d]: got %0d want %0d", i, q_p3, exp_q[i]); else pass_cnt++;
    end
    chk_cnt++; if (q_p4 !== 4'd0) $display("FAIL presc4_early: got %0d want 0", q_p4); else pass_cnt++;
    EN = 1'b1;
    cyc(1);
    chk_cnt++; if (q_p4 !== 4'd1) $display("FAIL presc4_step: got %0d want 1", q_p4); else pass_cnt++;
    chk_cnt++; if (q_p3 !== 4'd1) $display("FAIL presc3_phase: got %0d want 1", q_p3); else pass_cnt++;
  endtask

  task automatic test_load();
    EN = 1'b0; CLR = 1'b0; LOAD = 1'b1; D = 8'd12;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd9) $display("FAIL load_clamp: got %0d want 9", q_a); else pass_cnt++;
    chk_cnt++; if (q_b !== 8'd12) $display("FAIL load_b: got %0d want 12", q_b); else pass_cnt++;
    D = 8'd10;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd9) $display("FAIL load_clamp_edge: got %0d want 9", q_a); else pass_cnt++;
    D = 8'd8;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd8) $display("FAIL load_in_range: got %0d want 8", q_a); else pass_cnt++;
    CLR = 1'b1; D = 8'd5;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd0) $display("FAIL load_clr_prio: got %0d want 0", q_a); else pass_cnt++;
    chk_cnt++; if (q_b !== 8'd0) $display("FAIL load_clr_prio_b: got %0d want 0", q_b); else pass_cnt++;
    CLR = 1'b0; EN = 1'b1; UP = 1'b1; D = 8'd3;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd3) $display("FAIL load_over_tick: got %0d want 3", q_a); else pass_cnt++;
    D = 8'd0;
    cyc(1);
    UP = 1'b0; D = 8'd7;
    cyc(1);
    chk_cnt++; if (q_a !== 4'd7) $display("FAIL load_at_bound_q: got %0d want 7", q_a); else pass_cnt++;
    chk_cnt++; if (w_a !== 1'b0) $display("FAIL load_at_bound_wrap: got %b want 0", w_a); else pass_cnt++;
    LOAD = 1'b0; EN = 1'b0; UP = 1'b1; CLR = 1'b1;
    cyc(1);
    CLR = 1'b0; EN = 1'b1;
    cyc(1);
    LOAD = 1'b1; D = 8'd7;
    cyc(1);
    LOAD = 1'b0;
    chk_cnt++; if (q_p3 !== 4'd7) $display("FAIL load_presc_q: got %0d want 7", q_p3); else pass_cnt++;
    cyc(2);
    chk_cnt++; if (q_p3 !== 4'd7) $display("FAIL load_presc_restart: got %0d want 7", q_p3); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (q_p3 !== 4'd8) $display("FAIL load_presc_step: got %0d want 8", q_p3); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    EN = 1'b0; CLR = 1'b1;
    cyc(1);
    CLR = 1'b0; LOAD = 1'b1; D = 8'd5;
    cyc(1);
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    cyc(2);
    chk_cnt++; if (q_p4 !== 4'd5) $display("FAIL mid_pre_q: got %0d want 5", q_p4); else pass_cnt++;
    #2;
    RST_N = 1'b0;
    #1;
    chk_cnt++; if (q_p4 !== 4'd0) $display("FAIL mid_async_q: got %0d want 0", q_p4); else pass_cnt++;
    chk_cnt++; if (q_a !== 4'd0) $display("FAIL mid_async_q_a: got %0d want 0", q_a); else pass_cnt++;
    cyc(1);
    RST_N = 1'b1;
    cyc(3);
    chk_cnt++; if (q_p4 !== 4'd0) $display("FAIL mid_phase_discard: got %0d want 0", q_p4); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (q_p4 !== 4'd1) $display("FAIL mid_first_step: got %0d want 1", q_p4); else pass_cnt++;
  endtask

  task automatic test_binary_overflow();
    EN = 1'b0; UP = 1'b1; LOAD = 1'b1; D = 8'd255;
    cyc(1);
    LOAD = 1'b0;
    chk_cnt++; if (q_b !== 8'd255) $display("FAIL bin_load: got %0d want 255", q_b); else pass_cnt++;
    chk_cnt++; if (tc_b !== 1'b1) $display("FAIL bin_tc: got %b want 1", tc_b); else pass_cnt++;
    EN = 1'b1;
    cyc(1);
    chk_cnt++; if (q_b !== 8'd0) $display("FAIL bin_overflow_q: got %0d want 0", q_b); else pass_cnt++;
    chk_cnt++; if (w_b !== 1'b1) $display("FAIL bin_overflow_wrap: got %b want 1", w_b); else pass_cnt++;
    UP = 1'b0;
    cyc(1);
    chk_cnt++; if (q_b !== 8'd255) $display("FAIL bin_underflow_q: got %0d want 255", q_b); else pass_cnt++;
    chk_cnt++; if (w_b !== 1'b1) $display("FAIL bin_underflow_wrap: got %b want 1", w_b); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (q_b !== 8'd254) $display("FAIL bin_down_q: got %0d want 254", q_b); else pass_cnt++;
    chk_cnt++; if (w_b !== 1'b0) $display("FAIL bin_down_wrap: got %b want 0", w_b); else pass_cnt++;
  endtask

  task automatic test_random();
    int  mb, ms, mp, ph;
    int  nb, ns, np;
    bit  wb, ws, wp, tk3;
    EN = 1'b0; LOAD = 1'b0; CLR = 1'b1;
    cyc(1);
    mb = 0; ms = 0; mp = 0; ph = 0;
    for (int i = 0; i < 10000; i++) begin
      EN   = ($urandom_range(0, 3) != 0);
      UP   = $urandom_range(0, 1) == 1;
      LOAD = ($urandom_range(0, 15) == 0);
      CLR  = ($urandom_range(0, 63) == 0);
      D    = 8'($urandom_range(0, 255));
      tk3  = EN && (ph == 2);
      mstep(256, 1'b0, EN,  UP, CLR, LOAD, int'(D),        mb, nb, wb);
      mstep(10,  1'b1, EN,  UP, CLR, LOAD, int'(D[3:0]),   ms, ns, ws);
      mstep(10,  1'b0, tk3, UP, CLR, LOAD, int'(D[3:0]),   mp, np, wp);
      if (CLR || LOAD) ph = 0;
      else if (EN) ph = (ph == 2) ? 0 : ph + 1;
      cyc(1);
      chk_cnt++; if (q_b !== 8'(nb)) $display("FAIL rnd_q_b[%0d]: got %0d want %0d", i, q_b, nb); else pass_cnt++;
      chk_cnt++; if (w_b !== wb) $display("FAIL rnd_w_b[%0d]: got %b want %b", i, w_b, wb); else pass_cnt++;
      chk_cnt++; if (tc_b !== (UP ? nb == 255 : nb == 0)) $display("FAIL rnd_tc_b[%0d]: got %b want %b", i, tc_b, UP ? nb == 255 : nb == 0); else pass_cnt++;
      chk_cnt++; if (q_s !== 4'(ns)) $display("FAIL rnd_q_s[%0d]: got %0d want %0d", i, q_s, ns); else pass_cnt++;
      chk_cnt++; if (w_s !== ws) $display("FAIL rnd_w_s[%0d]: got %b want %b", i, w_s, ws); else pass_cnt++;
      chk_cnt++; if (q_p3 !== 4'(np)) $display("FAIL rnd_q_p3[%0d]: got %0d want %0d", i, q_p3, np); else pass_cnt++;
      chk_cnt++; if (w_p3 !== wp) $display("FAIL rnd_w_p3[%0d]: got %b want %b", i, w_p3, wp); else pass_cnt++;
      mb = nb; ms = ns; mp = np;
    end
    CLR = 1'b0; LOAD = 1'b0; EN = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; CLR = 1'b0; LOAD = 1'b0; EN = 1'b0; UP = 1'b0; D = 8'd0;
    test_reset();
    test_up_wrap();
    test_down();
    test_prescale();
    test_load();
    test_reset_mid();
    test_binary_overflow();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
